// File: rtl/sdm_seq_ctrl.sv
// sdm_seq_ctrl: sequencer and configuration front-end for the cascaded SDM
// sections. It accepts fractional words over valid/ready and walks the
// sections through clear -> settle -> run. A new word is applied in RUN only
// when the update period wraps.
// Optional feature: define SDM_DITHER_EN to add a 15-bit LFSR that dithers
// sec_din[0].
module sdm_seq_ctrl #(
  parameter int unsigned W          = 17,
  parameter int unsigned CLR_CYC    = 4,
  parameter int unsigned SETTLE_CYC = 64,
  parameter int unsigned UPD_PER    = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic         stop,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [W-2:0] cfg_frac,
  output logic         sec_clr,
  output logic         sec_en,
  output logic [W-1:0] sec_din,
  output logic         locked,
  output logic         busy
);

  localparam int unsigned MAX_A = (CLR_CYC > SETTLE_CYC) ? CLR_CYC : SETTLE_CYC;
  localparam int unsigned MAX_C = (MAX_A > UPD_PER) ? MAX_A : UPD_PER;
  localparam int unsigned CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CLEAR  = 2'd1,
    S_SETTLE = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  upd_q, upd_d;
  logic [W-2:0]   active_q, active_d;
  logic [W-2:0]   shadow_q, shadow_d;
  logic           pending_q, pending_d;

  logic           clr_d, en_d, locked_d, busy_d, ready_d;
  logic [W-1:0]   din_d;
  logic           hs;

`ifdef SDM_DITHER_EN
  logic [14:0]    lfsr_q, lfsr_d;
`endif

  assign hs = cfg_valid & cfg_ready;

  // Next-state, datapath and next-output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    upd_d     = upd_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;

    case (state_q)
      S_IDLE: begin
        if (hs) active_d = cfg_frac;
        if (start && !stop) begin
          state_d = S_CLEAR;
          cnt_d   = CW'(CLR_CYC - 1);
        end
      end
      S_CLEAR: begin
        if (cnt_q == '0) begin
          state_d = S_SETTLE;
          cnt_d   = CW'(SETTLE_CYC - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_RUN;
          upd_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RUN: begin
        if (hs) begin
          shadow_d  = cfg_frac;
          pending_d = 1'b1;
        end
        if (upd_q == CW'(UPD_PER - 1)) begin
          upd_d = '0;
          if (pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
          end
        end else begin
          upd_d = upd_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // stop overrides everything; active survives, only IDLE may load it
    if (stop) begin
      state_d   = S_IDLE;
      pending_d = 1'b0;
      cnt_d     = '0;
      upd_d     = '0;
      if (state_q != S_IDLE) active_d = active_q;
    end

    clr_d    = (state_d == S_CLEAR);
    en_d     = (state_d == S_SETTLE) || (state_d == S_RUN);
    locked_d = (state_d == S_RUN);
    busy_d   = (state_d != S_IDLE);
    ready_d  = (state_d == S_IDLE) || ((state_d == S_RUN) && !pending_d);
    din_d    = en_d ? {1'b0, active_d} : '0;

`ifdef SDM_DITHER_EN
    lfsr_d = lfsr_q;
    if ((state_d == S_CLEAR) && (state_q != S_CLEAR)) begin
      lfsr_d = 15'h0001;
    end else if (sec_en) begin
      lfsr_d = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
    end
    if (en_d) din_d[0] = active_d[0] ^ lfsr_d[0];
`endif
  end

  // State, counters, word registers and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      upd_q     <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      sec_clr   <= 1'b0;
      sec_en    <= 1'b0;
      sec_din   <= '0;
      locked    <= 1'b0;
      busy      <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      upd_q     <= upd_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      sec_clr   <= clr_d;
      sec_en    <= en_d;
      sec_din   <= din_d;
      locked    <= locked_d;
      busy      <= busy_d;
      cfg_ready <= ready_d;
    end
  end

`ifdef SDM_DITHER_EN
  // Dither LFSR, seeded on reset and on CLEAR entry
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) lfsr_q <= 15'h0001;
    else       lfsr_q <= lfsr_d;
  end
`endif

endmodule
